// File: rtl/uart_rx_ovs.sv
// Oversampled UART receiver: 2-FF synchronized rxd, mid-bit sampling on strb ticks, valid/ready byte output.
// Optional even parity bit and par_err output when UART_RX_PARITY_EN is defined.
module uart_rx_ovs #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 strb,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frm_err,
    output logic                 ovr_err,
`ifdef UART_RX_PARITY_EN
    output logic                 par_err,
`endif
    output logic                 busy
);
    localparam int TW = $clog2(OVS);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
`endif

    state_t                 state_q, state_d;
    logic                   rx_s1_q, rx_s1_d;
    logic                   rxs_q, rxs_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frm_err_q, frm_err_d;
    logic                   ovr_err_q, ovr_err_d;
    logic                   busy_q, busy_d;
    logic                   commit;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   par_err_q, par_err_d;
`endif

    always_comb begin
        rx_s1_d    = rxd;
        rxs_d      = rx_s1_q;
        state_d    = state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        frm_err_d  = 1'b0;
        ovr_err_d  = 1'b0;
        commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        par_err_d  = 1'b0;
`endif

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (strb) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d    = '0;
                        bit_idx_d = '0;
                        state_d   = rxs_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_END) begin
                        shift_d[bit_idx_q] = rxs_q;
                        bit_idx_d          = bit_idx_q + IW'(1);
                        if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_END) begin
                        par_bit_d = rxs_q;
                        state_d   = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_END) begin
                        if (rxs_q) begin
                            commit  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frm_err_d = 1'b1;
                            state_d   = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A pending unconsumed byte wins; the new one is dropped and flagged.
        if (commit) begin
            if (rx_valid_q && !rx_ready) begin
                ovr_err_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_err_d = ^{shift_q, par_bit_q};
`endif
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= rx_s1_d;
            rxs_q      <= rxs_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign frm_err  = frm_err_q;
    assign ovr_err  = ovr_err_q;
    assign busy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: table of frames plus glitch, break, overrun, mid-frame reset sequences.
// strb fires every 4th clk; each serial bit is held for 16 strb ticks.
module tb_uart_rx_ovs;
    logic       clk = 1'b0;
    logic       rst;
    logic       strb;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frm_err;
    logic       ovr_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int vclk   = 0;
    int nfrm   = 0;
    int novr   = 0;
    int npar   = 0;

    uart_rx_ovs dut (
        .clk      (clk),
        .rst      (rst),
        .strb     (strb),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err),
`ifdef UART_RX_PARITY_EN
        .par_err  (par_err),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        strb = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            strb = 1'b1;
            @(negedge clk);
            strb = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) vclk++;
        if (frm_err)  nfrm++;
        if (ovr_err)  novr++;
`ifdef UART_RX_PARITY_EN
        if (par_err)  npar++;
`endif
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!strb) @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        @(negedge clk);
        vclk = 0; nfrm = 0; novr = 0; npar = 0;
    endtask

    // The line is left at the stop-bit level; callers restore idle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_bad;
        wait_ticks(16);
`else
        if (par_bad) rxd = 1'b1;
`endif
        rxd = stop;
        wait_ticks(16);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_vclk;
        int         exp_frm;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] ff_byte;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h81, 1'b1, 8'h81, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 8'h81, 0, 1};
        vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1, 0};

        rst = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data",  32'(rx_data),  32'h00);
        check("reset busy",     32'(busy),     32'd0);
        check("reset frm_err",  32'(frm_err),  32'd0);
        check("reset ovr_err",  32'(ovr_err),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ticks(4);

        for (int v = 0; v < 6; v++) begin
            clear_counts();
            wait_ticks(1);
            send_frame(vecs[v].d, vecs[v].stop, 1'b0);
            rxd = 1'b1;
            wait_ticks(20);
            @(negedge clk);
            check($sformatf("vec%0d rx_data", v),    32'(rx_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d valid_clks", v), 32'(vclk),    32'(vecs[v].exp_vclk));
            check($sformatf("vec%0d frm_err", v),    32'(nfrm),    32'(vecs[v].exp_frm));
            check($sformatf("vec%0d ovr_err", v),    32'(novr),    32'd0);
            check($sformatf("vec%0d busy", v),       32'(busy),    32'd0);
        end

        // Start glitch shorter than half a bit
        clear_counts();
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(4);
        check("glitch busy high", 32'(busy), 32'd1);
        rxd = 1'b1;
        wait_ticks(6);
        check("glitch busy low", 32'(busy), 32'd0);
        wait_ticks(30);
        check("glitch valid", 32'(vclk), 32'd0);
        check("glitch frm",   32'(nfrm), 32'd0);

        // Framing error followed by a held-low break
        clear_counts();
        wait_ticks(1);
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(40);
        @(negedge clk);
        check("break frm pulses", 32'(nfrm), 32'd1);
        check("break valid",      32'(vclk), 32'd0);
        check("break busy",       32'(busy), 32'd1);
        rxd = 1'b1;
        wait_ticks(3);
        check("break exit busy", 32'(busy), 32'd0);

        // Back-to-back frames with no consumer
        rx_ready = 1'b0;
        clear_counts();
        wait_ticks(1);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_ticks(20);
        @(negedge clk);
        check("ovr rx_data",  32'(rx_data),  32'h11);
        check("ovr rx_valid", 32'(rx_valid), 32'd1);
        check("ovr pulses",   32'(novr),     32'd1);
        check("ovr frm",      32'(nfrm),     32'd0);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ovr drained", 32'(rx_valid), 32'd0);

        // Reset in the middle of bit 3 of 0xFF
        clear_counts();
        ff_byte = 8'hFF;
        wait_ticks(1);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rxd = ff_byte[i];
            wait_ticks(16);
        end
        rxd = ff_byte[3];
        wait_ticks(8);
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("midrst busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ticks(8);
        for (int i = 4; i < 8; i++) begin
            rxd = ff_byte[i];
            wait_ticks(16);
        end
        rxd = 1'b1;
        wait_ticks(16);
        check("midrst no byte", 32'(vclk), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_ticks(20);
        @(negedge clk);
        check("midrst rx_data", 32'(rx_data), 32'h5A);
        check("midrst valid",   32'(vclk),    32'd1);
        check("midrst frm",     32'(nfrm),    32'd0);
        check("midrst ovr",     32'(novr),    32'd0);

`ifdef UART_RX_PARITY_EN
        clear_counts();
        rx_ready = 1'b0;
        wait_ticks(1);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(20);
        @(negedge clk);
        check("par rx_data",  32'(rx_data),  32'h07);
        check("par rx_valid", 32'(rx_valid), 32'd1);
        check("par pulses",   32'(npar),     32'd1);
        rx_ready = 1'b1;
        wait_ticks(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
